// File: rtl/multi_counter_pkg.sv
// Shared command encodings and channel direction for the multi_counter tick/counter bank.
package multi_counter_pkg;

  typedef enum logic [1:0] {
    OP_MODE_UP      = 2'd0,
    OP_MODE_DOWN    = 2'd1,
    OP_PAUSE_TOGGLE = 2'd2,
    OP_LOAD         = 2'd3
  } cmd_op_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK by DIV into a one-cycle registered tick and a flipper that toggles per tick.
// step is the same-edge strobe so that consumers can update alongside tick.
module tick_prescaler
  import multi_counter_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic enable,
  output logic tick,
  output logic flipper,
  output logic step
);

  localparam int PW = cnt_w(DIV);

  logic [PW-1:0] p_q, p_d;
  logic          tick_q, flip_q;

  assign step = enable && (p_q == PW'(DIV - 1));

  always_comb begin
    p_d = p_q;
    if (enable) p_d = step ? '0 : p_q + PW'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      p_q    <= '0;
      tick_q <= 1'b0;
      flip_q <= 1'b0;
    end else begin
      p_q    <= p_d;
      tick_q <= step;
      if (step) flip_q <= ~flip_q;
    end
  end

  assign tick    = tick_q;
  assign flipper = flip_q;

endmodule

// File: rtl/multi_counter.sv
// Prescaled tick generator driving a bank of independent up/down/paused counters,
// reconfigured through a one-entry valid/ready command slot.
module multi_counter
  import multi_counter_pkg::*;
#(
  parameter int CLK_HZ   = 12000000,
  parameter int TICK_HZ  = 1,
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      enable,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [SELW-1:0]           cmd_sel,
  input  logic [1:0]                cmd_op,
  input  logic [WIDTH-1:0]          cmd_data,
  output logic                      cmd_err,
  output logic                      tick,
  output logic                      flipper,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;

  logic             step;
  logic             accept;
  logic             pend_vld_q;
  logic [SELW-1:0]  pend_sel_q;
  cmd_op_e          pend_op_q;
  logic [WIDTH-1:0] pend_data_q;
  logic             err_q;

  tick_prescaler #(.DIV(DIV)) u_presc (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .enable  (enable),
    .tick    (tick),
    .flipper (flipper),
    .step    (step)
  );

  // The slot is busy for exactly the cycle between accept and apply.
  assign accept    = cmd_valid && !pend_vld_q;
  assign cmd_ready = ~pend_vld_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_vld_q  <= 1'b0;
      pend_sel_q  <= '0;
      pend_op_q   <= OP_MODE_UP;
      pend_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      pend_vld_q <= accept;
      if (accept) begin
        pend_sel_q  <= cmd_sel;
        pend_op_q   <= cmd_op_e'(cmd_op);
        pend_data_q <= cmd_data;
      end
      err_q <= pend_vld_q && ({1'b0, pend_sel_q} >= (SELW + 1)'(CHANNELS));
    end
  end

  assign cmd_err = err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic             pause_q, pause_d;
    logic             wrap_q, wrap_d;
    logic             hit, adv;

    assign hit = pend_vld_q && (pend_sel_q == SELW'(i));
    assign adv = step && !pause_q;

    // Step with the registered mode first; an applied LOAD then overrides count and wrap.
    always_comb begin
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      pause_d = pause_q;
      wrap_d  = 1'b0;
      if (adv) begin
        if (dir_q == DIR_UP) begin
          cnt_d  = cnt_q + WIDTH'(1);
          wrap_d = &cnt_q;
        end else begin
          cnt_d  = cnt_q - WIDTH'(1);
          wrap_d = ~|cnt_q;
        end
      end
      if (hit) begin
        case (pend_op_q)
          OP_MODE_UP:      dir_d   = DIR_UP;
          OP_MODE_DOWN:    dir_d   = DIR_DOWN;
          OP_PAUSE_TOGGLE: pause_d = ~pause_q;
          OP_LOAD: begin
            cnt_d  = pend_data_q;
            wrap_d = 1'b0;
          end
          default: ;
        endcase
      end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        cnt_q   <= '0;
        dir_q   <= DIR_UP;
        pause_q <= 1'b0;
        wrap_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        dir_q   <= dir_d;
        pause_q <= pause_d;
        wrap_q  <= wrap_d;
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign wrap[i]                 = wrap_q;
  end

endmodule

// File: tb/tb_multi_counter.sv
// Directed scenarios plus random traffic on multi_counter, scored against a queue-based model.
module tb_multi_counter;
  import multi_counter_pkg::*;

  localparam int DIV = 10;
  localparam int W   = 8;
  localparam int CH  = 2;
  localparam int SW  = 2;

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic            enable = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [SW-1:0]   cmd_sel = '0;
  logic [1:0]      cmd_op = '0;
  logic [W-1:0]    cmd_data = '0;
  logic            cmd_err, tick, flipper;
  logic [CH*W-1:0] count;
  logic [CH-1:0]   wrap;

  multi_counter #(.CLK_HZ(10), .TICK_HZ(1), .WIDTH(W), .CHANNELS(CH), .SELW(SW)) dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_err(cmd_err),
    .tick(tick), .flipper(flipper), .count(count), .wrap(wrap)
  );

  always #5 CLK = ~CLK;

  int n_tot = 0;
  int n_bad = 0;

  typedef struct {int sel; int op; int data;} cmd_t;
  cmd_t pend_q[$];
  int   m_p;
  int   m_cnt[CH];
  bit   m_down[CH], m_pause[CH], m_wrap[CH];
  bit   m_tick, m_flip, m_err;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_p = 0; m_tick = 0; m_flip = 0; m_err = 0;
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0; m_down[i] = 0; m_pause[i] = 0; m_wrap[i] = 0;
    end
    pend_q.delete();
  endfunction

  task automatic chk_all();
    chk("ready", cmd_ready, pend_q.size() == 0);
    chk("tick", tick, m_tick);
    chk("flipper", flipper, m_flip);
    chk("err", cmd_err, m_err);
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("count%0d", i), count[i*W +: W], m_cnt[i]);
      chk($sformatf("wrap%0d", i), wrap[i], m_wrap[i]);
    end
  endtask

  // One rising edge: model advances from the pre-edge inputs, outputs checked 1ns later.
  task automatic cycle();
    bit   acc, tk;
    cmd_t nc, c;
    acc = cmd_valid && (pend_q.size() == 0);
    tk  = enable && (m_p == DIV - 1);
    nc  = '{int'(cmd_sel), int'(cmd_op), int'(cmd_data)};
    @(posedge CLK);
    m_err = 0;
    for (int i = 0; i < CH; i++) begin
      m_wrap[i] = 0;
      if (tk && !m_pause[i]) begin
        if (!m_down[i]) begin
          m_wrap[i] = (m_cnt[i] == 255);
          m_cnt[i]  = (m_cnt[i] + 1) % 256;
        end else begin
          m_wrap[i] = (m_cnt[i] == 0);
          m_cnt[i]  = (m_cnt[i] + 255) % 256;
        end
      end
    end
    if (pend_q.size() > 0) begin
      c = pend_q.pop_front();
      if (c.sel >= CH) m_err = 1;
      else begin
        case (c.op)
          0: m_down[c.sel] = 0;
          1: m_down[c.sel] = 1;
          2: m_pause[c.sel] = !m_pause[c.sel];
          default: begin m_cnt[c.sel] = c.data; m_wrap[c.sel] = 0; end
        endcase
      end
    end
    if (acc) pend_q.push_back(nc);
    m_tick = tk;
    if (tk) m_flip = !m_flip;
    if (enable) m_p = (m_p + 1) % DIV;
    #1 chk_all();
  endtask

  // Waits for a free slot, then presents the command for exactly its accept edge.
  task automatic send(int sel, int op, int data);
    int g = 0;
    while (pend_q.size() != 0 && g < 10) begin cycle(); g++; end
    cmd_valid = 1'b1;
    cmd_sel   = SW'(sel);
    cmd_op    = 2'(op);
    cmd_data  = W'(data);
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int g = 0;
    do begin cycle(); g++; end while (!m_tick && g < 2 * DIV);
    if (!m_tick) chk("wait_tick_timeout", 0, 1);
  endtask

  task automatic wait_p(int v);
    int g = 0;
    while (m_p != v && g < 2 * DIV) begin cycle(); g++; end
    if (m_p != v) chk("wait_p_timeout", 0, 1);
  endtask

  initial begin
    logic [CH*W-1:0] snap;
    logic            fsnap;
    m_reset();
    #12;
    chk_all();
    chk("rst_count", count, 0);
    chk("rst_ready", cmd_ready, 1);
    RST_N  = 1'b1;
    enable = 1'b1;

    for (int i = 1; i <= 35; i++) begin
      cycle();
      chk("tick_edge", tick, (i % 10) == 0);
      chk("flip_edge", flipper, (i / 10) % 2);
    end
    chk("run35_c0", count[0 +: W], 3);
    chk("run35_c1", count[W +: W], 3);

    send(0, OP_LOAD, 'hFF); cycle();
    chk("load_ff", count[0 +: W], 'hFF);
    wait_tick();
    chk("wrapup_c0", count[0 +: W], 0);
    chk("wrapup_w0", wrap[0], 1);
    chk("wrapup_c1", count[W +: W], 4);

    send(1, OP_LOAD, 0); cycle();
    send(1, OP_MODE_DOWN, 0); cycle();
    wait_tick();
    chk("wrapdn_c1", count[W +: W], 'hFF);
    chk("wrapdn_w1", wrap[1], 1);

    send(1, OP_MODE_UP, 0); cycle();
    send(1, OP_LOAD, 5); cycle();
    wait_p(8);
    send(0, OP_LOAD, 'h42);
    cycle();
    chk("coin_tick", tick, 1);
    chk("coin_c0", count[0 +: W], 'h42);
    chk("coin_w0", wrap[0], 0);
    chk("coin_c1", count[W +: W], 6);

    cycle();
    cmd_valid = 1'b1; cmd_sel = 1; cmd_op = OP_LOAD; cmd_data = 'h10;
    for (int k = 0; k < 4; k++) begin
      chk("rdy_pat", cmd_ready, (k % 2) == 0);
      cycle();
    end
    cmd_valid = 1'b0;
    cycle();
    chk("hold_c1", count[W +: W], 'h10);

    enable = 1'b0;
    cycle();
    snap  = count;
    fsnap = flipper;
    send(3, OP_LOAD, 'h99);
    chk("err_early", cmd_err, 0);
    cycle();
    chk("err_pulse", cmd_err, 1);
    cycle();
    chk("err_clear", cmd_err, 0);
    chk("frozen_cnt", count, snap);
    chk("frozen_flip", flipper, fsnap);

    send(0, OP_LOAD, 'h11);
    #2 RST_N = 1'b0;
    #1 m_reset();
    chk_all();
    chk("midrst_cnt", count, 0);
    chk("midrst_rdy", cmd_ready, 1);
    #3 RST_N = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("discard_c0", count[0 +: W], 0);

    for (int n = 0; n < 3000; n++) begin
      enable    = ($urandom % 8) != 0;
      cmd_valid = ($urandom % 3) == 0;
      cmd_sel   = SW'($urandom % 4);
      cmd_op    = 2'($urandom % 4);
      case ($urandom % 6)
        0: cmd_data = 'hFF;
        1: cmd_data = 'h00;
        2: cmd_data = 'hFE;
        default: cmd_data = W'($urandom);
      endcase
      cycle();
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
